// File: rtl/dmux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : dmux_rr_sched
// Purpose  : Round-robin scheduler that steers a 1-bit valid/ready item stream
//            onto one of N_CH channels of a 1xN demux. It searches for the next
//            enabled channel at or after a rotating pointer, waits there until
//            that channel's sink is ready, then strobes the item out.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            en_mask   - per-channel enable (live)
//            ch_ready  - per-channel sink ready
//            in_valid  - source has an item
//            in_data   - item bit
//            in_ready  - item accepted when in_valid && in_ready
//            s         - demux select (current channel)
//            a         - demux data input
//            strobe    - one-hot write strobe, aligned with a
//            busy      - scheduler is not idle
//            item_cnt  - delivered-item count, wraps
// Revision : 1.0 - initial release
// ============================================================================
module dmux_rr_sched #(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en_mask,
  input  logic [N_CH-1:0]   ch_ready,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic [SEL_W-1:0]  s,
  output logic              a,
  output logic [N_CH-1:0]   strobe,
  output logic              busy,
  output logic [CNT_W-1:0]  item_cnt
);

  localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [SEL_W-1:0]  s_nxt;
  logic              a_nxt;
  logic [N_CH-1:0]   strobe_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [SEL_W-1:0]  found;
  logic [SEL_W:0]    idx_sum;
  logic [SEL_W-1:0]  s_inc;
  logic              handshake;

  // Rotating priority search: walk offsets from the far end back to zero so
  // the smallest offset from ptr that hits an enabled channel wins.
  always_comb begin
    found   = ptr;
    idx_sum = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx_sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx_sum >= NUM_CH_EXT) begin
        idx_sum = idx_sum - NUM_CH_EXT;
      end
      if (en_mask[idx_sum[SEL_W-1:0]]) begin
        found = idx_sum[SEL_W-1:0];
      end
    end
  end

  // Pointer advances past the channel just served or abandoned.
  assign s_inc = (s == LAST_CH) ? '0 : s + 1'b1;

  assign in_ready  = (state == XFER) && en_mask[s] && ch_ready[s];
  assign handshake = in_valid && in_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    s_nxt      = s;
    a_nxt      = a;
    strobe_nxt = '0;
    cnt_nxt    = item_cnt;
    case (state)
      IDLE: begin
        if (in_valid && (|en_mask)) begin
          state_nxt = SEEK;
        end
      end
      SEEK: begin
        if (|en_mask) begin
          s_nxt     = found;
          state_nxt = XFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (handshake) begin
          a_nxt         = in_data;
          strobe_nxt[s] = 1'b1;
          ptr_nxt       = s_inc;
          cnt_nxt       = item_cnt + 1'b1;
          state_nxt     = SEEK;
        end else if (!en_mask[s]) begin
          // Channel disabled while waiting: give up on it and move on.
          ptr_nxt   = s_inc;
          state_nxt = SEEK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      s        <= '0;
      a        <= 1'b0;
      strobe   <= '0;
      item_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      s        <= s_nxt;
      a        <= a_nxt;
      strobe   <= strobe_nxt;
      item_cnt <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire
